// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl_if
// Brief    : Request/response bundle between the datapath and data_mem_ctrl.
// Revision : 1.0
// ============================================================================
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  SigSize;
  logic        LoadSigned;
  logic [31:0] ADD;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        rd_valid;
  logic        init_done;
  logic        misalign_err;

  modport master (
    output req_valid, MemWrite, MemRead, SigSize, LoadSigned, ADD, WriteData,
    input  req_ready, ReadData, rd_valid, init_done, misalign_err
  );

  modport slave (
    input  req_valid, MemWrite, MemRead, SigSize, LoadSigned, ADD, WriteData,
    output req_ready, ReadData, rd_valid, init_done, misalign_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Clocked byte-addressable little-endian data memory with zero-fill
//            after reset. Optional macro ALIGN_CHECK_EN rejects misaligned ops.
// Revision : 1.0
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH_BYTES);
  localparam int         c_CNT_W  = IDX_W - 2;
  localparam logic [0:0] c_S_INIT = 1'b0;
  localparam logic [0:0] c_S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_clr_cnt;
  logic [7:0]         r_mem [DEPTH_BYTES];
  logic [31:0]        r_rd_data;
  logic               r_rd_valid;

  logic               w_ready;
  logic               w_init_done;
  logic               w_acc;
  logic               w_misalign;
  logic               w_store;
  logic               w_load;
  logic [3:0]         w_be;
  logic [IDX_W-1:0]   w_idx [4];
  logic [7:0]         w_rbyte [4];
  logic [31:0]        w_rd_ext;
  logic               w_unused_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_S_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_INIT: if (&r_clr_cnt) w_state_nxt = c_S_RUN;
      default:  w_state_nxt = c_S_RUN;
    endcase
  end

  always_comb begin
    w_ready     = (r_state == c_S_RUN);
    w_init_done = (r_state == c_S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  r_clr_cnt <= '0;
    else if (r_state == c_S_INIT) r_clr_cnt <= r_clr_cnt + c_CNT_W'(1);
  end

  always_comb begin
    w_acc = bus.req_valid & w_ready;
    case (bus.SigSize)
      2'b00:   w_be = 4'b0001;
      2'b01:   w_be = 4'b0011;
      default: w_be = 4'b1111;
    endcase
`ifdef ALIGN_CHECK_EN
    w_misalign = ((bus.SigSize == 2'b01) && bus.ADD[0]) ||
                 (bus.SigSize[1] && (bus.ADD[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    // A store wins when both MemWrite and MemRead are set.
    w_store = w_acc & bus.MemWrite & ~w_misalign;
    w_load  = w_acc & bus.MemRead & ~bus.MemWrite & ~w_misalign;
  end

  // Byte lanes wrap naturally at the top of the array via IDX_W-bit adds.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k]   = bus.ADD[IDX_W-1:0] + IDX_W'(k);
      w_rbyte[k] = r_mem[w_idx[k]];
    end
    case (bus.SigSize)
      2'b00:   w_rd_ext = {{24{bus.LoadSigned & w_rbyte[0][7]}}, w_rbyte[0]};
      2'b01:   w_rd_ext = {{16{bus.LoadSigned & w_rbyte[1][7]}}, w_rbyte[1], w_rbyte[0]};
      default: w_rd_ext = {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
    endcase
  end

  assign w_unused_addr = ^bus.ADD[31:IDX_W];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == c_S_INIT) begin
        for (int k = 0; k < 4; k++) r_mem[{r_clr_cnt, 2'(k)}] <= 8'h00;
      end else if (w_store) begin
        for (int k = 0; k < 4; k++)
          if (w_be[k]) r_mem[w_idx[k]] <= bus.WriteData[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_load;
      if (w_load) r_rd_data <= w_rd_ext;
    end
  end

`ifdef ALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_acc & w_misalign;
  end
  assign bus.misalign_err = r_misalign;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.req_ready = w_ready;
  assign bus.init_done = w_init_done;
  assign bus.ReadData  = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Directed bench for data_mem_ctrl with a byte-array reference model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_ctrl;
  localparam int DEPTH   = 1024;
  localparam int CLR_CYC = DEPTH / 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  data_mem_ctrl_if bus();

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset release plus a plain byte array.
  int          m_cyc = 0;
  logic        m_rdv;
  logic        m_mis;
  logic [31:0] m_rd;
  logic [7:0]  m_mem [DEPTH];
  logic [31:0] lit_q [$];

  always @(posedge clk) begin
    int          n;
    bit          mis;
    logic [31:0] v;
    if (!rst_n) begin
      m_cyc <= 0;
      m_rdv <= 1'b0;
      m_mis <= 1'b0;
      m_rd  <= 32'h0;
    end else begin
      m_rdv <= 1'b0;
      m_mis <= 1'b0;
      if (m_cyc < CLR_CYC) begin
        m_cyc <= m_cyc + 1;
        if (m_cyc == CLR_CYC - 1)
          for (int i = 0; i < DEPTH; i++) m_mem[i] <= 8'h00;
      end else if (bus.req_valid) begin
        n   = (bus.SigSize == 2'b00) ? 1 : (bus.SigSize == 2'b01) ? 2 : 4;
        mis = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis = ((n == 2) && (bus.ADD % 2 != 0)) || ((n == 4) && (bus.ADD % 4 != 0));
`endif
        if (mis) begin
          m_mis <= 1'b1;
        end else if (bus.MemWrite) begin
          for (int k = 0; k < n; k++)
            m_mem[(bus.ADD + k) % DEPTH] <= bus.WriteData[8*k +: 8];
        end else if (bus.MemRead) begin
          v = 32'h0;
          for (int k = 0; k < n; k++)
            v = v | (32'(m_mem[(bus.ADD + k) % DEPTH]) << (8*k));
          if (bus.LoadSigned && (n < 4) && v[8*n-1])
            v = v | ~((32'd1 << (8*n)) - 32'd1);
          m_rdv <= 1'b1;
          m_rd  <= v;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",    32'(bus.req_ready),    32'(m_cyc >= CLR_CYC));
      check("init_done",    32'(bus.init_done),    32'(m_cyc >= CLR_CYC));
      check("rd_valid",     32'(bus.rd_valid),     32'(m_rdv));
      check("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
      check("ReadData",     bus.ReadData,          m_rd);
      if (bus.rd_valid && lit_q.size() > 0) check("lit_rd", bus.ReadData, lit_q.pop_front());
    end
  end

  task automatic drive(input bit v, input bit w, input bit r, input logic [1:0] sz,
                       input bit ls, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.req_valid  = v;
    bus.MemWrite   = w;
    bus.MemRead    = r;
    bus.SigSize    = sz;
    bus.LoadSigned = ls;
    bus.ADD        = a;
    bus.WriteData  = wd;
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    drive(1'b1, 1'b1, 1'b0, sz, 1'b0, a, wd);
  endtask

  task automatic ld(input logic [1:0] sz, input bit ls, input logic [31:0] a, input logic [31:0] exp);
    lit_q.push_back(exp);
    drive(1'b1, 1'b0, 1'b1, sz, ls, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // Counts negedges from reset release until req_ready rises (bounded).
  task automatic wait_init(input int exp_cyc);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!bus.req_ready && i < 400);
    check("init_cycles", i, exp_cyc);
    check("init_done_at_ready", 32'(bus.init_done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    bus.SigSize = 2'b00; bus.LoadSigned = 1'b0; bus.ADD = 32'h0; bus.WriteData = 32'h0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init(257);

    ld(2'b10, 1'b0, 32'h3FC, 32'h0000_0000);
    st(2'b10, 32'h10, 32'h8899AABB);
    ld(2'b00, 1'b1, 32'h11, 32'hFFFF_FFAA);
    ld(2'b01, 1'b0, 32'h12, 32'h0000_8899);
    st(2'b10, 32'h20, 32'h11223344);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_007F);
    ld(2'b10, 1'b0, 32'h20, 32'h1122_337F);
`ifdef ALIGN_CHECK_EN
    st(2'b01, 32'h21, 32'h0000_FFFF);
    ld(2'b10, 1'b0, 32'h20, 32'h1122_337F);
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h0);
    ld(2'b00, 1'b0, 32'h23, 32'h0000_0011);
`else
    st(2'b10, 32'h3FE, 32'hDEADBEEF);
    ld(2'b00, 1'b0, 32'h3FE, 32'h0000_00EF);
    ld(2'b00, 1'b0, 32'h3FF, 32'h0000_00BE);
    ld(2'b00, 1'b0, 32'h000, 32'h0000_00AD);
    ld(2'b00, 1'b0, 32'h001, 32'h0000_00DE);
    ld(2'b10, 1'b0, 32'h3FE, 32'hDEAD_BEEF);
    ld(2'b01, 1'b1, 32'h3FF, 32'hFFFF_ADBE);
`endif
    st(2'b01, 32'h40, 32'h0000_8001);
    ld(2'b01, 1'b1, 32'h40, 32'hFFFF_8001);
    ld(2'b00, 1'b0, 32'h41, 32'h0000_0080);
    ld(2'b01, 1'b1, 32'h11, 32'hFFFF_99AA);
    idle(3);
    check("lit_drained_1", lit_q.size(), 0);

    // Reset pulse partway through zero-fill restarts it from the beginning.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init(257);
    ld(2'b10, 1'b0, 32'h10, 32'h0000_0000);
    ld(2'b10, 1'b0, 32'h20, 32'h0000_0000);

    // Reset coinciding with a load request drops the response.
    st(2'b10, 32'h80, 32'h12345678);
    ld(2'b10, 1'b0, 32'h80, 32'h1234_5678);
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    bus.MemRead   = 1'b0;
    @(negedge clk);
    check("rd_valid_dropped", 32'(bus.rd_valid), 32'd0);
    wait_init(256);
    ld(2'b10, 1'b0, 32'h80, 32'h0000_0000);
    idle(3);
    check("lit_drained_2", lit_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
